// File: rtl/store_narrow_unit.sv
// Sub-word store unit: byte/half stores via read-modify-write, word stores written directly; optional STORE_NARROW_BIG_ENDIAN_EN selects big-endian lanes.
// Latency: accept->done is 2 cycles for word, 4 for byte/half, 1 for misaligned or illegal requests.
// Backpressure: req_ready is high only in IDLE; req_* inputs are ignored while a store is in flight.
module store_narrow_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic [1:0]            req_size,
    output logic                  done,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic                  mem_rd,
    input  logic [31:0]           mem_rdata,
    output logic                  mem_wr,
    output logic [31:0]           mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  err_q, err_d;
    logic                  half_q, half_d;      // 1: halfword store, 0: byte store
    logic [1:0]            off_q, off_d;        // byte offset within the word
    logic [15:0]           data_q, data_d;      // low bits of store data for sub-word merge
    logic [ADDR_WIDTH-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic                  req_bad;
    logic [1:0]            byte_lane;
    logic                  half_lane;
    logic [31:0]           merged;

    // Misaligned or illegal request detection on the incoming request.
    always_comb begin
        req_bad = (req_size == 2'b11)
                | ((req_size == 2'b01) & req_addr[0])
                | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
    end

    // Lane selection and merge of the stored bits into the word read back from memory.
    always_comb begin
`ifdef STORE_NARROW_BIG_ENDIAN_EN
        byte_lane = 2'd3 - off_q;
        half_lane = ~off_q[1];
`else
        byte_lane = off_q;
        half_lane = off_q[1];
`endif
        merged = mem_rdata;
        if (half_q) begin
            merged[{half_lane, 4'b0000} +: 16] = data_q;
        end else begin
            merged[{byte_lane, 3'b000} +: 8] = data_q[7:0];
        end
    end

    // Next-state and datapath capture for the store sequencer.
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        half_d      = half_q;
        off_d       = off_q;
        data_d      = data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    mem_addr_d = req_addr[ADDR_WIDTH-1:2];
                    off_d      = req_addr[1:0];
                    half_d     = (req_size == 2'b01);
                    data_d     = req_data[15:0];
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (req_size == 2'b10) begin
                        err_d       = 1'b0;
                        mem_wdata_d = req_data;
                        state_d     = S_WRITE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = S_MERGE;
            S_MERGE: begin
                mem_wdata_d = merged;
                state_d     = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            err_q       <= 1'b0;
            half_q      <= 1'b0;
            off_q       <= 2'b00;
            data_q      <= 16'h0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            half_q      <= half_d;
            off_q       <= off_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Strobes decode straight from the state register so reset clears them at once.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        mem_rd     = (state_q == S_READ);
        mem_wr     = (state_q == S_WRITE);
        done       = (state_q == S_DONE);
        misaligned = (state_q == S_DONE) & err_q;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit with a behavioural synchronous RAM.
// Latency checked per request: cycle of mem_rd, mem_wr and done relative to the accept edge.
// Backpressure: requests wait on req_ready with a bounded cycle budget.
module tb_store_narrow_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        done;
    logic        misaligned;
    logic [29:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_wr;
    logic [31:0] mem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:63];

    store_narrow_unit #(.ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .done       (done),
        .misaligned (misaligned),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM without byte enables: read data appears the cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata = mem[mem_addr[5:0]];
        if (mem_wr) mem[mem_addr[5:0]] = mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] pre;
        logic [31:0] exp_wd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                                input logic [31:0] p, input logic [31:0] w, input logic e);
        vec_t v;
        v.addr = a; v.data = d; v.size = s; v.pre = p; v.exp_wd = w; v.exp_err = e;
        return v;
    endfunction

    // Issue one request and record when each strobe appears, counted in cycles after the accept edge.
    task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                           output int rd_k, output int wr_k, output int done_k,
                           output int rd_n, output int wr_n, output int overlap,
                           output logic mis, output logic [31:0] wd, output logic [29:0] wa);
        int w;
        rd_k = 0; wr_k = 0; done_k = 0; rd_n = 0; wr_n = 0; overlap = 0;
        mis = 1'b0; wd = 32'h0; wa = 30'h0;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_req", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (mem_rd) begin
                rd_n++;
                if (rd_k == 0) rd_k = k;
            end
            if (mem_wr) begin
                wr_n++;
                wr_k = k; wd = mem_wdata; wa = mem_addr;
            end
            if (mem_rd && mem_wr) overlap++;
            if (done) begin
                done_k = k;
                mis = misaligned;
                break;
            end
        end
    endtask

    initial begin
        int rd_k, wr_k, done_k, rd_n, wr_n, ov, dn;
        logic mis;
        logic [31:0] wd;
        logic [29:0] wa;
        logic sub;
        int idx;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_data = 32'h0; req_size = 2'b00;

`ifdef STORE_NARROW_BIG_ENDIAN_EN
        vecs[0] = mk(32'h10, 32'hDEADBEEF, 2'b10, 32'h0,        32'hDEADBEEF, 1'b0);
        vecs[1] = mk(32'h22, 32'hFFFFFFAB, 2'b00, 32'h11223344, 32'h1122AB44, 1'b0);
        vecs[2] = mk(32'h22, 32'h0000CAFE, 2'b01, 32'h11223344, 32'h1122CAFE, 1'b0);
        vecs[3] = mk(32'h20, 32'h00000055, 2'b00, 32'h11223344, 32'h55223344, 1'b0);
        vecs[4] = mk(32'h23, 32'h00000066, 2'b00, 32'h11223344, 32'h11223366, 1'b0);
        vecs[5] = mk(32'h21, 32'h00000077, 2'b00, 32'h11223344, 32'h11772344, 1'b0);
        vecs[6] = mk(32'h20, 32'h1234BEEF, 2'b01, 32'h11223344, 32'hBEEF3344, 1'b0);
`else
        vecs[0] = mk(32'h10, 32'hDEADBEEF, 2'b10, 32'h0,        32'hDEADBEEF, 1'b0);
        vecs[1] = mk(32'h22, 32'hFFFFFFAB, 2'b00, 32'h11223344, 32'h11AB3344, 1'b0);
        vecs[2] = mk(32'h22, 32'h0000CAFE, 2'b01, 32'h11223344, 32'hCAFE3344, 1'b0);
        vecs[3] = mk(32'h20, 32'h00000055, 2'b00, 32'h11223344, 32'h11223355, 1'b0);
        vecs[4] = mk(32'h23, 32'h00000066, 2'b00, 32'h11223344, 32'h66223344, 1'b0);
        vecs[5] = mk(32'h21, 32'h00000077, 2'b00, 32'h11223344, 32'h11227744, 1'b0);
        vecs[6] = mk(32'h20, 32'h1234BEEF, 2'b01, 32'h11223344, 32'h1122BEEF, 1'b0);
`endif
        vecs[7] = mk(32'h21, 32'h0000CAFE, 2'b01, 32'h11223344, 32'h0, 1'b1);
        vecs[8] = mk(32'h22, 32'hDEADBEEF, 2'b10, 32'h11223344, 32'h0, 1'b1);
        vecs[9] = mk(32'h20, 32'hDEADBEEF, 2'b11, 32'h11223344, 32'h0, 1'b1);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",      {31'b0, req_ready},  32'h1);
        chk("rst_done",       {31'b0, done},       32'h0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
        chk("rst_mem_rd",     {31'b0, mem_rd},     32'h0);
        chk("rst_mem_wr",     {31'b0, mem_wr},     32'h0);
        chk("rst_mem_addr",   {2'b0, mem_addr},    32'h0);
        chk("rst_mem_wdata",  mem_wdata,           32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single requests
        for (int i = 0; i < 10; i++) begin
            idx = int'(vecs[i].addr[7:2]);
            mem[idx] = vecs[i].pre;
            sub = (vecs[i].size != 2'b10);
            run_req(vecs[i].addr, vecs[i].data, vecs[i].size, rd_k, wr_k, done_k, rd_n, wr_n, ov, mis, wd, wa);
            chk($sformatf("v%0d_misaligned", i), {31'b0, mis}, {31'b0, vecs[i].exp_err});
            chk($sformatf("v%0d_overlap", i), ov, 0);
            if (vecs[i].exp_err) begin
                chk($sformatf("v%0d_done_k", i), done_k, 1);
                chk($sformatf("v%0d_rd_n", i), rd_n, 0);
                chk($sformatf("v%0d_wr_n", i), wr_n, 0);
            end else begin
                chk($sformatf("v%0d_done_k", i), done_k, sub ? 4 : 2);
                chk($sformatf("v%0d_rd_k", i), rd_k, sub ? 1 : 0);
                chk($sformatf("v%0d_rd_n", i), rd_n, sub ? 1 : 0);
                chk($sformatf("v%0d_wr_k", i), wr_k, sub ? 3 : 1);
                chk($sformatf("v%0d_wr_n", i), wr_n, 1);
                chk($sformatf("v%0d_wdata", i), wd, vecs[i].exp_wd);
                chk($sformatf("v%0d_mem_addr", i), {2'b0, wa}, {2'b0, vecs[i].addr[31:2]});
            end
            chk($sformatf("v%0d_mem_final", i), mem[idx], vecs[i].exp_err ? vecs[i].pre : vecs[i].exp_wd);
        end

        // Back-to-back: SB then SW with req_valid held high
        mem[8]  = 32'h11223344;
        mem[12] = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h22; req_data = 32'hFFFFFFAB; req_size = 2'b00;
        @(posedge clk);
        rd_k = 0; done_k = 0; dn = 0; wr_k = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_addr = 32'h30; req_data = 32'hCAFEF00D; req_size = 2'b10;
            end
            if (req_ready && rd_k == 0) rd_k = k;
            if (done) begin
                dn++;
                if (dn == 1) wr_k = k;
                if (dn == 2) begin
                    done_k = k;
                    req_valid = 1'b0;
                    break;
                end
            end
        end
        req_valid = 1'b0;
        chk("b2b_first_done",   wr_k,    4);
        chk("b2b_second_accept", rd_k,   5);
        chk("b2b_second_done",  done_k,  7);
        chk("b2b_mem_sb",       mem[8],  32'h11223344 ^ 32'h11223344 ^
`ifdef STORE_NARROW_BIG_ENDIAN_EN
                                         32'h1122AB44);
`else
                                         32'h11AB3344);
`endif
        chk("b2b_mem_sw",       mem[12], 32'hCAFEF00D);
        repeat (2) @(negedge clk);

        // Reset asserted during WRITE abandons the store
        mem[5] = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h14; req_data = 32'hA5A5A5A5; req_size = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_wr_before", {31'b0, mem_wr}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_wr_drop",    {31'b0, mem_wr},   32'h0);
        chk("rstmid_ready",      {31'b0, req_ready}, 32'h1);
        chk("rstmid_mem_wdata",  mem_wdata,          32'h0);
        dn = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (done || mem_wr || mem_rd) dn++;
        end
        chk("rstmid_no_done", dn, 0);
        chk("rstmid_mem_kept", mem[5], 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
